im_loader: RTL

Boot-time instruction-memory writer. Accepts a program image as a valid/ready word stream, writes it into the IM `SRAM_wrapper` port, and holds the CPU until the load finishes. It then reads the image back, checks the word sum against an expected checksum, and reports done/error. It sits in `top` between an external image source and IM1. A mux in `top` gives IM1's port to `im_loader` while `cpu_hold` is high and to the CPU's `pc` fetch otherwise.

---
 rtl/im_loader_pkg.sv | 7 +
 rtl/im_loader_if.sv | 25 ++
 rtl/im_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/im_loader_pkg.sv
// Shared types and default widths for the boot-time instruction-memory loader.
package loader_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} ld_state_e;
endpackage

// File: rtl/im_loader_if.sv
// Image stream plus IM SRAM port, seen from the loader (master) or its environment (slave).
interface im_loader_if #(
    parameter int ADDR_W = loader_pkg::ADDR_W_DEF,
    parameter int DATA_W = loader_pkg::DATA_W_DEF
) ();
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              IM_CEB;
    logic              IM_WEB;
    logic [DATA_W-1:0] IM_BWEB;
    logic [ADDR_W-1:0] IM_A;
    logic [DATA_W-1:0] IM_DI;
    logic [DATA_W-1:0] IM_DO;

    modport master (
        input  s_valid, s_data, IM_DO,
        output s_ready, IM_CEB, IM_WEB, IM_BWEB, IM_A, IM_DI
    );

    modport slave (
        output s_valid, s_data, IM_DO,
        input  s_ready, IM_CEB, IM_WEB, IM_BWEB, IM_A, IM_DI
    );
endinterface

// File: rtl/im_loader.sv
// Streams a program image into IM, reads it back, and checks the word sum.
// Holds the CPU off the IM port until the load has finished.
module im_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_cnt,
    input  logic [DATA_W-1:0] exp_sum,
    im_loader_if.master       bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    ld_state_e         state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   wr_idx;
    logic [ADDR_W:0]   rd_idx;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] wr_sum;
    logic [DATA_W-1:0] rd_sum;
    logic [DATA_W-1:0] rd_sum_nxt;
    logic              rd_vld;
    logic              wr_fire;
    logic              err_nxt;

    assign busy     = (state != IDLE);
    assign cpu_hold = busy | ~rst;

    always_comb begin
        state_nxt   = state;
        wr_fire     = 1'b0;
        bus.s_ready = 1'b0;
        bus.IM_CEB  = 1'b1;
        bus.IM_WEB  = 1'b1;
        bus.IM_BWEB = '1;
        bus.IM_A    = '0;
        bus.IM_DI   = '0;
        // IM_DO belongs to the read issued last cycle
        rd_sum_nxt  = rd_sum + (rd_vld ? bus.IM_DO : '0);
        err_nxt     = (rd_sum_nxt != exp_q) || (wr_sum != exp_q);
        case (state)
            IDLE: begin
                if (start && word_cnt != '0)
                    state_nxt = WRITE;
            end
            WRITE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    wr_fire     = 1'b1;
                    bus.IM_CEB  = 1'b0;
                    bus.IM_WEB  = 1'b0;
                    bus.IM_BWEB = '0;
                    bus.IM_A    = base + wr_idx[ADDR_W-1:0];
                    bus.IM_DI   = bus.s_data;
                    if (wr_idx + 1'b1 == cnt)
                        state_nxt = READ;
                end
            end
            READ: begin
                bus.IM_CEB = 1'b0;
                bus.IM_A   = base + rd_idx[ADDR_W-1:0];
                if (rd_idx + 1'b1 == cnt)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            base   <= '0;
            cnt    <= '0;
            exp_q  <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            wr_sum <= '0;
            rd_sum <= '0;
            rd_vld <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= 1'b0;
            rd_vld <= (state == READ);
            case (state)
                IDLE: begin
                    if (start) begin
                        base   <= base_addr;
                        cnt    <= word_cnt;
                        exp_q  <= exp_sum;
                        wr_idx <= '0;
                        rd_idx <= '0;
                        wr_sum <= '0;
                        rd_sum <= '0;
                        err    <= 1'b0;
                        // an empty image completes immediately
                        if (word_cnt == '0)
                            done <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        wr_sum <= wr_sum + bus.s_data;
                        wr_idx <= wr_idx + 1'b1;
                    end
                end
                READ: begin
                    rd_idx <= rd_idx + 1'b1;
                    rd_sum <= rd_sum_nxt;
                end
                DRAIN: begin
                    rd_sum <= rd_sum_nxt;
                    done   <= 1'b1;
                    err    <= err_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule
